// File: rtl/mem_port_arbiter_if.sv
// Request/grant and buffer-port bundle between two requesters, the arbiter and
// a dual-port buffer with registered read data.
interface mem_port_arbiter_if #(
    parameter int In_W       = 32,
    parameter int In_D_Add_W = 4
);
    logic                   wr_req;
    logic [In_D_Add_W-1:0]  wr_addr;
    logic signed [In_W-1:0] wr_data;
    logic                   wr_gnt;

    logic                   rd_req;
    logic [In_D_Add_W-1:0]  rd_addr;
    logic                   rd_gnt;
    logic signed [In_W-1:0] rd_data;
    logic                   rd_valid;

    logic                   mem_ena;
    logic                   mem_wea;
    logic                   mem_enb;
    logic [In_D_Add_W-1:0]  mem_addra;
    logic [In_D_Add_W-1:0]  mem_addrb;
    logic signed [In_W-1:0] mem_dina;
    logic signed [In_W-1:0] mem_doutb;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_doutb,
        output wr_gnt, rd_gnt, rd_data, rd_valid,
               mem_ena, mem_wea, mem_enb, mem_addra, mem_addrb, mem_dina
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_doutb,
        input  wr_gnt, rd_gnt, rd_data, rd_valid,
               mem_ena, mem_wea, mem_enb, mem_addra, mem_addrb, mem_dina
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one buffer operation per cycle between a writer
// and a reader; grants are combinational, read data arrives one cycle later.
//
// state  | meaning
// IDLE   | no grant last cycle (treated as reader-owned, writer wins conflict)
// WR_OWN | last grant went to the writer
// RD_OWN | last grant went to the reader
module mem_port_arbiter #(
    parameter int In_W       = 32,
    parameter int In_D_Add_W = 4,
    parameter int Max_Burst  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WR_OWN, RD_OWN} state_t;

    localparam logic [3:0] MAX_B = 4'(Max_Burst);

    state_t                 state_q, state_d;
    logic [3:0]             burst_cnt_q, burst_cnt_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [In_D_Add_W-1:0]  addra_q, addra_d;
    logic [In_D_Add_W-1:0]  addrb_q, addrb_d;
    logic signed [In_W-1:0] dina_q, dina_d;
    logic                   wr_gnt, rd_gnt;
    logic [3:0]             burst_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= 4'd0;
            rd_valid_q  <= 1'b0;
            addra_q     <= '0;
            addrb_q     <= '0;
            dina_q      <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rd_valid_q  <= rd_valid_d;
            addra_q     <= addra_d;
            addrb_q     <= addrb_d;
            dina_q      <= dina_d;
        end
    end

    always_comb begin
        wr_gnt      = 1'b0;
        rd_gnt      = 1'b0;
        state_d     = IDLE;
        burst_cnt_d = 4'd0;
        addra_d     = addra_q;
        addrb_d     = addrb_q;
        dina_d      = dina_q;
        burst_inc   = (burst_cnt_q >= MAX_B) ? MAX_B : burst_cnt_q + 4'd1;

        // Alternating on conflict also enforces the burst limit, since the
        // owner never keeps the port while the other side waits.
        if (rst_n) begin
            if (bus.wr_req && bus.rd_req) begin
                if (state_q == WR_OWN) rd_gnt = 1'b1;
                else                   wr_gnt = 1'b1;
            end else begin
                wr_gnt = bus.wr_req;
                rd_gnt = bus.rd_req;
            end
        end

        if (wr_gnt) begin
            state_d     = WR_OWN;
            burst_cnt_d = (state_q == WR_OWN) ? burst_inc : 4'd1;
            addra_d     = bus.wr_addr;
            dina_d      = bus.wr_data;
        end else if (rd_gnt) begin
            state_d     = RD_OWN;
            burst_cnt_d = (state_q == RD_OWN) ? burst_inc : 4'd1;
            addrb_d     = bus.rd_addr;
        end
        rd_valid_d = rd_gnt;
    end

    assign bus.wr_gnt    = wr_gnt;
    assign bus.rd_gnt    = rd_gnt;
    assign bus.mem_ena   = wr_gnt;
    assign bus.mem_wea   = wr_gnt;
    assign bus.mem_enb   = rd_gnt;
    assign bus.mem_addra = addra_d;
    assign bus.mem_addrb = addrb_d;
    assign bus.mem_dina  = dina_d;
    // A read granted just before reset must not surface as valid.
    assign bus.rd_valid  = rd_valid_q && rst_n;
    assign bus.rd_data   = bus.mem_doutb;

    gnt_exclusive: assert property (@(posedge clk) !(wr_gnt && rd_gnt));
    burst_bounded: assert property (@(posedge clk) burst_cnt_q <= MAX_B);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of the arbiter against a grant/data reference
// model; two instances cover Max_Burst=4 and Max_Burst=1.
module tb_mem_port_arbiter;
    localparam int W  = 32;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.In_W(W), .In_D_Add_W(AW)) b4 ();
    mem_port_arbiter_if #(.In_W(W), .In_D_Add_W(AW)) b1 ();

    mem_port_arbiter #(.In_W(W), .In_D_Add_W(AW), .Max_Burst(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4));
    mem_port_arbiter #(.In_W(W), .In_D_Add_W(AW), .Max_Burst(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1));

    // attached buffers: registered read port
    logic signed [W-1:0] buf4 [16];
    logic signed [W-1:0] buf1 [16];
    always @(posedge clk) begin
        if (b4.mem_ena && b4.mem_wea) buf4[b4.mem_addra] <= b4.mem_dina;
        if (b4.mem_enb && !b4.mem_wea) b4.mem_doutb <= buf4[b4.mem_addrb];
        if (b1.mem_ena && b1.mem_wea) buf1[b1.mem_addra] <= b1.mem_dina;
        if (b1.mem_enb && !b1.mem_wea) b1.mem_doutb <= buf1[b1.mem_addrb];
    end

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    int                  last_own;   // 0 none, 1 writer, 2 reader
    bit                  exp_valid;
    logic signed [W-1:0] exp_rdata;
    logic signed [W-1:0] ref_mem [16];
    bit                  hold_a_v, hold_b_v;
    logic [AW-1:0]       hold_a, hold_b;
    logic signed [W-1:0] hold_d;
    bit                  eg_w, eg_r;
    int                  n_w1, n_r1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic check_dut(input string p, input bit r,
                             input logic [AW-1:0] wa, input logic signed [W-1:0] wd,
                             input logic [AW-1:0] ra,
                             input logic wg, input logic rg, input logic ena,
                             input logic wea, input logic enb,
                             input logic [AW-1:0] addra, input logic [AW-1:0] addrb,
                             input logic signed [W-1:0] dina, input logic rv,
                             input logic signed [W-1:0] rdata);
        chk({p, ".wr_gnt"}, 64'(wg), 64'(eg_w));
        chk({p, ".rd_gnt"}, 64'(rg), 64'(eg_r));
        chk({p, ".mem_ena"}, 64'(ena), 64'(eg_w));
        chk({p, ".mem_wea"}, 64'(wea), 64'(eg_w));
        chk({p, ".mem_enb"}, 64'(enb), 64'(eg_r));
        chk({p, ".rd_valid"}, 64'(rv), 64'(exp_valid && r));
        if (exp_valid && r) chk({p, ".rd_data"}, 64'(rdata), 64'(exp_rdata));
        if (eg_w) begin
            chk({p, ".mem_addra"}, 64'(addra), 64'(wa));
            chk({p, ".mem_dina"}, 64'(dina), 64'(wd));
        end else if (hold_a_v) begin
            chk({p, ".addra_hold"}, 64'(addra), 64'(hold_a));
            chk({p, ".dina_hold"}, 64'(dina), 64'(hold_d));
        end
        if (eg_r) chk({p, ".mem_addrb"}, 64'(addrb), 64'(ra));
        else if (hold_b_v) chk({p, ".addrb_hold"}, 64'(addrb), 64'(hold_b));
    endtask

    // one clock cycle: drive, check mid-cycle, advance model, cross the edge
    task automatic step(input bit r, input bit wq, input logic [AW-1:0] wa,
                        input logic signed [W-1:0] wd, input bit rq,
                        input logic [AW-1:0] ra);
        rst_n = r;
        b4.wr_req = wq; b4.wr_addr = wa; b4.wr_data = wd; b4.rd_req = rq; b4.rd_addr = ra;
        b1.wr_req = wq; b1.wr_addr = wa; b1.wr_data = wd; b1.rd_req = rq; b1.rd_addr = ra;
        #4;
        eg_w = 1'b0;
        eg_r = 1'b0;
        if (r) begin
            if (wq && rq) begin
                if (last_own == 1) eg_r = 1'b1;
                else               eg_w = 1'b1;
            end else begin
                eg_w = wq;
                eg_r = rq;
            end
        end
        check_dut("m4", r, wa, wd, ra, b4.wr_gnt, b4.rd_gnt, b4.mem_ena, b4.mem_wea,
                  b4.mem_enb, b4.mem_addra, b4.mem_addrb, b4.mem_dina, b4.rd_valid, b4.rd_data);
        check_dut("m1", r, wa, wd, ra, b1.wr_gnt, b1.rd_gnt, b1.mem_ena, b1.mem_wea,
                  b1.mem_enb, b1.mem_addra, b1.mem_addrb, b1.mem_dina, b1.rd_valid, b1.rd_data);
        if (b1.wr_gnt) n_w1++;
        if (b1.rd_gnt) n_r1++;
        if (!r) begin
            last_own  = 0;
            exp_valid = 1'b0;
            hold_a_v  = 1'b0;
            hold_b_v  = 1'b0;
        end else begin
            last_own  = eg_w ? 1 : (eg_r ? 2 : 0);
            exp_valid = eg_r;
            if (eg_r) begin
                exp_rdata = ref_mem[ra];
                hold_b    = ra;
                hold_b_v  = 1'b1;
            end
            if (eg_w) begin
                ref_mem[wa] = wd;
                hold_a      = wa;
                hold_d      = wd;
                hold_a_v    = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    bit                  wq, rq, r;
    logic [AW-1:0]       wa, ra;
    logic signed [W-1:0] wd;

    initial begin
        for (int i = 0; i < 16; i++) begin
            buf4[i] = '0; buf1[i] = '0; ref_mem[i] = '0;
        end
        b4.mem_doutb = '0;
        b1.mem_doutb = '0;
        last_own = 0; exp_valid = 0; exp_rdata = '0;
        hold_a_v = 0; hold_b_v = 0; hold_a = '0; hold_b = '0; hold_d = '0;
        n_w1 = 0; n_r1 = 0;
        @(posedge clk); #1;

        // reset with both requesting: nothing granted
        step(0, 1, 4'd1, 32'h11, 1, 4'd2);
        step(0, 1, 4'd1, 32'h11, 1, 4'd2);

        // lone write right after release
        step(1, 1, 4'd3, 32'h55, 0, 4'd0);
        // write then read same address
        step(1, 1, 4'd5, 32'h1234, 0, 4'd0);
        step(1, 0, 4'd0, 32'h0, 1, 4'd5);
        step(1, 0, 4'd0, 32'h0, 0, 4'd0);

        // both requesting continuously: strict alternation, 4 + 4 grants
        n_w1 = 0; n_r1 = 0;
        for (int i = 0; i < 8; i++) step(1, 1, 4'd7, 32'h100, 1, 4'd7);
        chk("mb1.wr_count", 64'(n_w1), 64'd4);
        chk("mb1.rd_count", 64'(n_r1), 64'd4);
        step(1, 0, 4'd0, 32'h0, 0, 4'd0);

        // reader alone long enough to saturate, then writer joins
        for (int i = 0; i < 6; i++) step(1, 0, 4'd0, 32'h0, 1, 4'd2);
        step(1, 1, 4'd9, -32'sd7, 1, 4'd2);
        step(1, 0, 4'd0, 32'h0, 1, 4'd9);

        // reset the cycle after a read grant, then conflict goes to writer
        step(1, 0, 4'd0, 32'h0, 1, 4'd3);
        step(0, 1, 4'd4, 32'h44, 1, 4'd3);
        step(1, 1, 4'd4, 32'h44, 1, 4'd3);
        step(1, 1, 4'd4, 32'h44, 1, 4'd3);

        // random traffic; requesters hold until granted, occasional reset
        wq = 0; rq = 0; wa = '0; ra = '0; wd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!wq) begin
                wq = ($urandom_range(0, 2) != 0);
                wa = AW'($urandom_range(0, 15));
                wd = $urandom;
            end
            if (!rq) begin
                rq = ($urandom_range(0, 2) != 0);
                ra = AW'($urandom_range(0, 15));
            end
            r = ($urandom_range(0, 49) != 0);
            step(r, wq, wa, wd, rq, ra);
            if (eg_w) wq = 0;
            if (eg_r) rq = 0;
        end
        step(1, 0, 4'd0, 32'h0, 0, 4'd0);
        step(1, 0, 4'd0, 32'h0, 0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
